// File: rtl/program_loader.sv
// Instruction-memory writer: assembles an MSB-first byte stream into words and
// writes them to consecutive addresses from 0, holding busy for the whole load.
module program_loader #(
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int PC_WIDTH          = 5,
  parameter int WORD_COUNT        = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  output logic                         wr_en,
  output logic [PC_WIDTH-1:0]          wr_addr,
  output logic [INSTRUCTION_WIDTH-1:0] wr_data,
  output logic                         busy,
  output logic                         done
);

  localparam int BYTES = (INSTRUCTION_WIDTH + 7) / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]    LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [PC_WIDTH-1:0] LAST_ADDR = PC_WIDTH'(WORD_COUNT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [PC_WIDTH-1:0]          addr_q, addr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [INSTRUCTION_WIDTH-1:0] shift_q, shift_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_LOAD: begin
        if (byte_valid) begin
          // Truncating cast drops the excess high bits of the first byte.
          shift_d = INSTRUCTION_WIDTH'({shift_q, byte_in});
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = ST_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Address and word are held in flops that are stable throughout WRITE.
  assign wr_addr    = addr_q;
  assign wr_data    = shift_q;
  assign byte_ready = (state_q == ST_LOAD);
  assign wr_en      = (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a cycle table on a single-word
// instance plus model-checked full loads with stalls, stray start and reset.
module tb_program_loader;

  localparam int IW = 40;
  localparam int PW = 5;
  localparam int WC = 32;
  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          start1 = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_in = 8'h00;

  logic          byte_ready, wr_en, busy, done;
  logic [PW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic          rdy1, wr1, bsy1, dn1;
  logic [PW-1:0] wa1;
  logic [IW-1:0] wd1;

  program_loader #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .WORD_COUNT(WC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  program_loader #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .WORD_COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy1), .wr_en(wr1),
    .wr_addr(wa1), .wr_data(wd1), .busy(bsy1), .done(dn1)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [PW-1:0] wa_q[$];
  logic [IW-1:0] wd_q[$];
  int unsigned   done_cyc[$];

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      chk("ready_during_write", {63'd0, byte_ready}, 64'd0);
    end
    if (done) done_cyc.push_back(cyc);
  end

  logic [7:0] stream [NB*WC];

  function automatic logic [IW-1:0] model_word(input int k);
    logic [IW-1:0] w = '0;
    for (int b = 0; b < NB; b++) w = (w << 8) | IW'(stream[k*NB + b]);
    return w;
  endfunction

  task automatic fill_a0();
    for (int k = 0; k < WC; k++)
      for (int b = 0; b < NB; b++) stream[k*NB + b] = 8'(8'hA0 + k);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NB*WC; i++) stream[i] = 8'($urandom);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cyc.delete();
  endtask

  task automatic do_start(output int unsigned s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic send_stream(input int n, input int start_at, input bit rnd);
    int idx = 0;
    int budget = 0;
    while (idx < n && budget < 4000) begin
      byte_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_in    = byte_valid ? stream[idx] : 8'($urandom);
      start      = (idx == start_at);
      @(negedge clk);
      if (byte_valid && byte_ready) idx++;
      @(posedge clk); #1;
      budget++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    chk("bytes_consumed", 64'(idx), 64'(n));
  endtask

  task automatic check_load(input int unsigned s, input bit timed);
    int w = 0;
    while (done_cyc.size() == 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("done_count", 64'(done_cyc.size()), 64'd1);
    if (timed && done_cyc.size() > 0) chk("done_latency", 64'(done_cyc[0] - s), 64'd192);
    chk("write_count", 64'(wa_q.size()), 64'(WC));
    for (int k = 0; k < WC && k < wa_q.size(); k++) begin
      chk("wr_addr", 64'(wa_q[k]), 64'(k));
      chk("wr_data", 64'(wd_q[k]), 64'(model_word(k)));
    end
    @(negedge clk);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    logic          st;
    logic          vld;
    logic [7:0]    b;
    logic          rdy;
    logic          wr;
    logic          bsy;
    logic          dn;
    logic [PW-1:0] a;
    logic [IW-1:0] d;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned s;

    tbl[0] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 40'h0};
    tbl[1] = '{1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 40'h0};
    tbl[2] = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 40'h0};
    tbl[3] = '{1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 40'h0};
    tbl[4] = '{1'b0, 1'b1, 8'h56, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 40'h0};
    tbl[5] = '{1'b0, 1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 40'h0};
    tbl[6] = '{1'b0, 1'b1, 8'h9A, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 40'h123456789A};
    tbl[7] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 40'h0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 40'h0};
    tbl[9] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 40'h0};

    // Reset and idle behaviour
    byte_valid = 1'b1;
    byte_in    = 8'hC3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, byte_ready}, 64'd0);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_ready", {63'd0, byte_ready}, 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);
    end
    byte_valid = 1'b0;

    // Single-word instance, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      start1     = tbl[i].st;
      byte_valid = tbl[i].vld;
      byte_in    = tbl[i].b;
      @(posedge clk); #1;
      chk($sformatf("w1_ready[%0d]", i), {63'd0, rdy1}, {63'd0, tbl[i].rdy});
      chk($sformatf("w1_wr_en[%0d]", i), {63'd0, wr1}, {63'd0, tbl[i].wr});
      chk($sformatf("w1_busy[%0d]", i), {63'd0, bsy1}, {63'd0, tbl[i].bsy});
      chk($sformatf("w1_done[%0d]", i), {63'd0, dn1}, {63'd0, tbl[i].dn});
      if (tbl[i].wr) begin
        chk("w1_wr_addr", 64'(wa1), 64'(tbl[i].a));
        chk("w1_wr_data", 64'(wd1), 64'(tbl[i].d));
      end
    end
    start1     = 1'b0;
    byte_valid = 1'b0;
    chk("idle_no_write", 64'(wa_q.size()), 64'd0);

    // Full gap-free default load
    fill_a0();
    clear_log();
    do_start(s);
    send_stream(NB*WC, -1, 1'b0);
    check_load(s, 1'b1);

    // Same image with random back-pressure
    clear_log();
    do_start(s);
    send_stream(NB*WC, -1, 1'b1);
    check_load(s, 1'b0);

    // Random image with random back-pressure
    fill_rand();
    clear_log();
    do_start(s);
    send_stream(NB*WC, -1, 1'b1);
    check_load(s, 1'b0);

    // Stray start midway through word 3
    fill_a0();
    clear_log();
    do_start(s);
    send_stream(NB*WC, 3*NB + 2, 1'b0);
    check_load(s, 1'b1);

    // Reset after two bytes of word 5
    clear_log();
    do_start(s);
    send_stream(5*NB + 2, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, byte_ready}, 64'd0);
    chk("midrst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
    chk("midrst_wr_data", 64'(wr_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_writes", 64'(wa_q.size()), 64'd5);
    chk("midrst_no_done", 64'(done_cyc.size()), 64'd0);
    for (int k = 0; k < wa_q.size(); k++) chk("midrst_addr", 64'(wa_q[k]), 64'(k));

    fill_rand();
    clear_log();
    @(posedge clk); #1;
    do_start(s);
    send_stream(NB*WC, -1, 1'b0);
    check_load(s, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the instruction memory. The block accepts a byte stream from a host link (UART or debug bridge) over a valid/ready handshake and assembles the bytes MSB-first into `INSTRUCTION_WIDTH`-bit words. It issues one write per word into the instruction memory at consecutive addresses starting at 0. It holds `busy` high for the whole load, so the core is kept stalled while the program image is replaced.

## Interface

**Parameters**
- `INSTRUCTION_WIDTH`, default 40: instruction word width; must match the instruction memory.
- `PC_WIDTH`, default 5: address width; must match the memory port.
- `WORD_COUNT`, default 32: number of words per load, range 1..2^`PC_WIDTH`.
- Derived localparam `BYTES` = ceil(`INSTRUCTION_WIDTH`/8), which is 5 at the defaults.

**Ports**
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: pulse that begins a load. Sampled only in IDLE.
- `byte_in`, input, 8: stream data.
- `byte_valid`, input, 1: `byte_in` is valid.
- `byte_ready`, output, 1: loader can accept a byte.
- `wr_en`, output, 1: one-cycle write strobe to the instruction memory.
- `wr_addr`, output, `PC_WIDTH`: write address.
- `wr_data`, output, `INSTRUCTION_WIDTH`: assembled instruction word.
- `busy`, output, 1: high in LOAD, WRITE and DONE.
- `done`, output, 1: one-cycle pulse when the last word has been written.

## Operation

**States:** IDLE, LOAD, WRITE, DONE.

**IDLE**
- `byte_ready`=0. Bytes on the stream are ignored.
- On `start`=1: go to LOAD, clear the address counter and byte counter, clear the shift register.

**LOAD**
- `byte_ready`=1.
- A byte is accepted on an edge where `byte_valid` && `byte_ready`.
- On accept: shift register ← {shift[W-9:0], `byte_in`}. The first byte received ends up in the most-significant bits.
- When `INSTRUCTION_WIDTH` is not a multiple of 8, the excess high bits of the first byte are discarded.
- The byte counter increments on each accept. On accepting byte number `BYTES`-1, go to WRITE and reset the byte counter to 0.
- `byte_valid` low stalls indefinitely. There is no timeout.

**WRITE** (exactly one cycle)
- `wr_en`=1, `wr_data`=assembled word, `wr_addr`=address counter.
- `byte_ready`=0.
- Next state:
  - If address == `WORD_COUNT`-1: DONE.
  - Otherwise: increment the address and go to LOAD.

**DONE** (exactly one cycle)
- `done`=1, then IDLE.

**Boundary rules**
- `start` in LOAD, WRITE or DONE is ignored. A load cannot be restarted except by reset.
- `start` and `byte_valid` in the same IDLE cycle: the byte is not accepted.
- With `WORD_COUNT` = 2^`PC_WIDTH`, the address never wraps. The last write goes to all-ones, then the block goes to DONE.
- Reset mid-load:
  - All state is cleared immediately and the partial word is discarded.
  - Words already written stay in memory.
  - No `wr_en` or `done` is produced for the aborted load.

**Outputs**
- `wr_data` and `wr_addr` are stable whenever `wr_en`=1. Their value at other times is don't-care, but they must be registered.

## Timing

- **Reset values:** state=IDLE, `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0.
- **Output decode:** `byte_ready`, `wr_en`, `busy` and `done` are decoded from registered state only. There is no combinational path from any input to any output.
- **Write latency:** if the last byte of a word is accepted at edge N, `wr_en` is high from edge N to edge N+1. The memory captures the word at edge N+1.
- **Start latency:** `start` sampled at edge S puts the block in LOAD with `byte_ready`=1 after edge S.
- **Throughput:** with `byte_valid` held high, each word takes `BYTES`+1 cycles.
  - A full default load (32 × 6 cycles) ends with `done` high 192 cycles after the edge on which `start` was sampled.
- **`busy` window:** rises after the edge sampling `start`; falls after the DONE cycle.

## Test plan

- **Reset/idle:** hold `rst_n`=0, then release.
  - All outputs are 0.
  - `byte_valid`=1 in IDLE gives `byte_ready`=0 and no write.
- **Single word** (`WORD_COUNT`=1): `start`, then bytes 0x12, 0x34, 0x56, 0x78, 0x9A back-to-back.
  - Exactly one `wr_en` pulse with `wr_addr`=0, `wr_data`=0x123456789A.
  - `done` the following cycle; `busy` falls after it.
- **Full default load:** 160 bytes, where word k's bytes are 0xA0+k repeated five times.
  - 32 writes, addresses 0..31 in order, `wr_data`[k]=0x(A0+k)×5.
  - `done` 192 cycles after `start`; no address wrap.
- **Back-pressure and stalls:** toggle `byte_valid` randomly.
  - Only bytes on valid&&ready edges are consumed.
  - No bytes are accepted during WRITE.
  - Word contents are identical to the gap-free run.
- **`start` during load:** pulse `start` midway through word 3.
  - Ignored: addresses continue 3, 4, … and no restart at 0.
- **Reset mid-word:** assert `rst_n`=0 after 2 bytes of word 5.
  - Immediate return to reset values, with no write to address 5.
  - A new `start` then loads from address 0 correctly.
